// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit majority vote,
// one-cycle valid / frame_err pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_PRE  = CW'(HALF - 1);
  localparam logic [CW-1:0] C_MID  = CW'(HALF);
  localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic          rxMeta;
  logic          rxs;
  logic          rxsPrev;
  logic [CW-1:0] cnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shReg;
  logic          smpA;
  logic          smpB;
  logic          maj;

  // third sample is the live rxs on the decision cycle
  assign maj  = (smpA & smpB) | (smpA & rxs) | (smpB & rxs);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rxMeta    <= 1'b1;
      rxs       <= 1'b1;
      rxsPrev   <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bitIdx    <= '0;
      shReg     <= '0;
      smpA      <= 1'b0;
      smpB      <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rxMeta    <= rx;
      rxs       <= rxMeta;
      rxsPrev   <= rxs;
      valid     <= 1'b0;
      frame_err <= 1'b0;

      if (cnt == C_LAST)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (cnt == C_PRE)
        smpA <= rxs;
      if (cnt == C_MID)
        smpB <= rxs;

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rxsPrev && !rxs)
            state <= START;
        end
        START: begin
          if (cnt == C_DEC && maj) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == C_LAST) begin
            state  <= DATA;
            bitIdx <= '0;
          end
        end
        DATA: begin
          if (cnt == C_DEC)
            shReg <= {maj, shReg[7:1]};
          if (cnt == C_LAST) begin
            bitIdx <= bitIdx + 3'd1;
            if (bitIdx == 3'd7)
              state <= STOP;
          end
        end
        STOP: begin
          // leave early so a start edge right after the stop bit is caught
          if (cnt == C_DEC) begin
            state <= IDLE;
            cnt   <= '0;
            if (maj) begin
              data  <= shReg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
